// File: rtl/cronometro_bcd.sv
// MM:SS BCD stopwatch. The seconds time base comes from the divider's slow
// square wave (every edge of tick_in is one second). The start/stop and clear
// pushbuttons are synchronized and debounced. Four active-low seven-segment
// displays are driven from the registered digits.
module cronometro_bcd #(
  parameter int MAX_MINUTES     = 59,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  output logic [3:0] sec_uni,
  output logic [3:0] sec_dez,
  output logic [3:0] min_uni,
  output logic [3:0] min_dez,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic       running,
  output logic       volta
);

  localparam int              CNT_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      MAX_MIN_DEZ = 4'(MAX_MINUTES / 10);
  localparam logic [3:0]      MAX_MIN_UNI = 4'(MAX_MINUTES % 10);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Index 0 is the start/stop key, index 1 is the clear key.
  logic [1:0]       key_sync1_r, key_sync2_r, key_db_r;
  logic [CNT_W-1:0] db_cnt_r [0:1];
  logic [1:0]       key_accept_s, key_press_s;

  logic   tick_ff1_r, tick_ff2_r, tick_ff3_r;
  logic   tick_event_s;

  state_t     state_r, state_next_s;
  logic [3:0] sec_uni_r, sec_dez_r, min_uni_r, min_dez_r;
  logic [3:0] sec_uni_next_s, sec_dez_next_s, min_uni_next_s, min_dez_next_s;
  logic       wrap_s, count_en_s;
  logic       running_r, volta_r;

  // A key's new level is accepted on the cycle its counter completes; a press is a 1->0 accept.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      key_accept_s[i] = (key_sync2_r[i] != key_db_r[i]) && (db_cnt_r[i] == CNT_LAST);
      key_press_s[i]  = key_accept_s[i] && !key_sync2_r[i];
    end
  end

  // Key synchronizers and debounce counters; any reversion restarts the count.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      key_sync1_r <= 2'b11;
      key_sync2_r <= 2'b11;
      key_db_r    <= 2'b11;
      for (int i = 0; i < 2; i++) db_cnt_r[i] <= '0;
    end else begin
      key_sync1_r <= {key_clear_n, key_start_n};
      key_sync2_r <= key_sync1_r;
      for (int i = 0; i < 2; i++) begin
        if (key_sync2_r[i] != key_db_r[i]) begin
          if (key_accept_s[i]) begin
            key_db_r[i] <= key_sync2_r[i];
            db_cnt_r[i] <= '0;
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + CNT_W'(1);
          end
        end else begin
          db_cnt_r[i] <= '0;
        end
      end
    end
  end

  // Tick synchronizer plus one history stage for edge detection on either polarity.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      tick_ff1_r <= 1'b0;
      tick_ff2_r <= 1'b0;
      tick_ff3_r <= 1'b0;
    end else begin
      tick_ff1_r <= tick_in;
      tick_ff2_r <= tick_ff1_r;
      tick_ff3_r <= tick_ff2_r;
    end
  end

  assign tick_event_s = tick_ff2_r ^ tick_ff3_r;

  // Next state: clear dominates, then start/stop toggles between RUN and PAUSE.
  always_comb begin
    state_next_s = state_r;
    if (key_press_s[1]) begin
      state_next_s = ST_IDLE;
    end else if (key_press_s[0]) begin
      case (state_r)
        ST_IDLE:  state_next_s = ST_RUN;
        ST_RUN:   state_next_s = ST_PAUSE;
        ST_PAUSE: state_next_s = ST_RUN;
        default:  state_next_s = ST_IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Counting is judged on the pre-edge state, so a tick with a start press still counts in RUN.
  assign count_en_s = tick_event_s && (state_r == ST_RUN) && !key_press_s[1];

  // BCD cascade for the next digit values and the wrap flag.
  always_comb begin
    sec_uni_next_s = sec_uni_r;
    sec_dez_next_s = sec_dez_r;
    min_uni_next_s = min_uni_r;
    min_dez_next_s = min_dez_r;
    wrap_s         = 1'b0;
    if (key_press_s[1]) begin
      sec_uni_next_s = 4'd0;
      sec_dez_next_s = 4'd0;
      min_uni_next_s = 4'd0;
      min_dez_next_s = 4'd0;
    end else if (count_en_s) begin
      if (sec_uni_r < 4'd9) begin
        sec_uni_next_s = sec_uni_r + 4'd1;
      end else begin
        sec_uni_next_s = 4'd0;
        if (sec_dez_r < 4'd5) begin
          sec_dez_next_s = sec_dez_r + 4'd1;
        end else begin
          sec_dez_next_s = 4'd0;
          if ((min_dez_r == MAX_MIN_DEZ) && (min_uni_r == MAX_MIN_UNI)) begin
            min_uni_next_s = 4'd0;
            min_dez_next_s = 4'd0;
            wrap_s         = 1'b1;
          end else if (min_uni_r >= 4'd9) begin
            min_uni_next_s = 4'd0;
            min_dez_next_s = min_dez_r + 4'd1;
          end else begin
            min_uni_next_s = min_uni_r + 4'd1;
          end
        end
      end
    end else begin
      wrap_s = 1'b0;
    end
  end

  // State, digits and status flags are all registered together.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      sec_uni_r <= 4'd0;
      sec_dez_r <= 4'd0;
      min_uni_r <= 4'd0;
      min_dez_r <= 4'd0;
      running_r <= 1'b0;
      volta_r   <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      sec_uni_r <= sec_uni_next_s;
      sec_dez_r <= sec_dez_next_s;
      min_uni_r <= min_uni_next_s;
      min_dez_r <= min_dez_next_s;
      running_r <= (state_next_s == ST_RUN);
      volta_r   <= wrap_s;
    end
  end

  assign sec_uni = sec_uni_r;
  assign sec_dez = sec_dez_r;
  assign min_uni = min_uni_r;
  assign min_dez = min_dez_r;
  assign running = running_r;
  assign volta   = volta_r;
  assign hex0    = seg7(sec_uni_r);
  assign hex1    = seg7(sec_dez_r);
  assign hex2    = seg7(min_uni_r);
  assign hex3    = seg7(min_dez_r);

endmodule

// File: tb/tb_cronometro_bcd.sv
// Directed bench for cronometro_bcd with short debounce (4 cycles).
module tb_cronometro_bcd;

  logic       clock_50 = 1'b0;
  logic       reset = 1'b1;
  logic       tick_in = 1'b0;
  logic       key_start_n = 1'b1;
  logic       key_clear_n = 1'b1;
  logic [3:0] sec_uni, sec_dez, min_uni, min_dez;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic       running, volta;
  logic [15:0] mmss;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] SEG_0 = 7'b1000000;

  cronometro_bcd #(.MAX_MINUTES(59), .DEBOUNCE_CYCLES(4)) dut (
    .clock_50(clock_50), .reset(reset), .tick_in(tick_in),
    .key_start_n(key_start_n), .key_clear_n(key_clear_n),
    .sec_uni(sec_uni), .sec_dez(sec_dez), .min_uni(min_uni), .min_dez(min_dez),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .running(running), .volta(volta)
  );

  always #5 clock_50 = ~clock_50;

  assign mmss = {min_dez, min_uni, sec_dez, sec_uni};

  // Press one key for 'hold' cycles, then release and let the debouncer settle.
  task automatic press_key(input bit clr, input int hold);
    @(negedge clock_50);
    if (clr) key_clear_n = 1'b0;
    else     key_start_n = 1'b0;
    repeat (hold) @(negedge clock_50);
    key_clear_n = 1'b1;
    key_start_n = 1'b1;
    repeat (10) @(negedge clock_50);
  endtask

  // n tick transitions, one per cycle, then drain the synchronizer.
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock_50);
      tick_in = ~tick_in;
    end
    repeat (3) @(negedge clock_50);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock_50);
    reset = 1'b0;
    checks++; if (mmss !== 16'h0000) begin failures++; $display("FAIL reset_digits got=%h exp=0000", mmss); end
    checks++; if (running !== 1'b0 || volta !== 1'b0) begin failures++; $display("FAIL reset_flags running=%b volta=%b exp=0 0", running, volta); end
    checks++; if ({hex3, hex2, hex1, hex0} !== {4{SEG_0}}) begin failures++; $display("FAIL reset_hex got=%h exp=%h", {hex3, hex2, hex1, hex0}, {4{SEG_0}}); end
    run_ticks(5);
    checks++; if (mmss !== 16'h0000) begin failures++; $display("FAIL idle_ticks got=%h exp=0000", mmss); end
    checks++; if (hex0 !== SEG_0 || running !== 1'b0) begin failures++; $display("FAIL idle_hex0 hex0=%b running=%b exp=%b 0", hex0, running, SEG_0); end
  endtask

  task automatic test_start_count;
    press_key(1'b0, 6);
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL start_running got=%b exp=1", running); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock_50);
      tick_in = ~tick_in;
      repeat (2) @(negedge clock_50);
      checks++; if (sec_uni !== 4'(k - 1)) begin failures++; $display("FAIL tick_early k=%0d got=%0d exp=%0d", k, sec_uni, k - 1); end
      @(negedge clock_50);
      checks++; if (sec_uni !== 4'(k)) begin failures++; $display("FAIL tick_land k=%0d got=%0d exp=%0d", k, sec_uni, k); end
    end
    checks++; if (hex0 !== 7'b0110000) begin failures++; $display("FAIL hex0_three got=%b exp=0110000", hex0); end
  endtask

  task automatic test_glitch;
    press_key(1'b1, 6);
    checks++; if (running !== 1'b0 || mmss !== 16'h0000) begin failures++; $display("FAIL clear_idle running=%b digits=%h exp=0 0000", running, mmss); end
    @(negedge clock_50); key_start_n = 1'b0;
    repeat (3) @(negedge clock_50); key_start_n = 1'b1;
    repeat (2) @(negedge clock_50); key_start_n = 1'b0;
    repeat (3) @(negedge clock_50); key_start_n = 1'b1;
    repeat (10) @(negedge clock_50);
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL glitch_ignored running=%b exp=0", running); end
    press_key(1'b0, 4);
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL glitch_then_press running=%b exp=1", running); end
  endtask

  task automatic test_wrap;
    run_ticks(3598);
    checks++; if (mmss !== 16'h5958) begin failures++; $display("FAIL preload got=%h exp=5958", mmss); end
    run_ticks(1);
    checks++; if (mmss !== 16'h5959) begin failures++; $display("FAIL max_time got=%h exp=5959", mmss); end
    checks++; if ({hex3, hex2, hex1, hex0} !== {7'b0010010, 7'b0010000, 7'b0010010, 7'b0010000}) begin
      failures++; $display("FAIL hex_5959 got=%b_%b_%b_%b exp=0010010_0010000_0010010_0010000", hex3, hex2, hex1, hex0);
    end
    @(negedge clock_50);
    tick_in = ~tick_in;
    repeat (2) @(negedge clock_50);
    checks++; if (mmss !== 16'h5959 || volta !== 1'b0) begin failures++; $display("FAIL pre_wrap digits=%h volta=%b exp=5959 0", mmss, volta); end
    @(negedge clock_50);
    checks++; if (mmss !== 16'h0000 || volta !== 1'b1 || running !== 1'b1) begin
      failures++; $display("FAIL wrap digits=%h volta=%b running=%b exp=0000 1 1", mmss, volta, running);
    end
    @(negedge clock_50);
    checks++; if (volta !== 1'b0) begin failures++; $display("FAIL volta_width got=%b exp=0", volta); end
  endtask

  task automatic test_pause;
    run_ticks(7);
    checks++; if (mmss !== 16'h0007) begin failures++; $display("FAIL at_0007 got=%h exp=0007", mmss); end
    press_key(1'b0, 6);
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL pause_running got=%b exp=0", running); end
    run_ticks(4);
    checks++; if (mmss !== 16'h0007) begin failures++; $display("FAIL pause_hold got=%h exp=0007", mmss); end
    press_key(1'b0, 6);
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL resume_running got=%b exp=1", running); end
    run_ticks(1);
    checks++; if (mmss !== 16'h0008) begin failures++; $display("FAIL resume_count got=%h exp=0008", mmss); end
  endtask

  task automatic test_clear_with_tick;
    run_ticks(746);
    checks++; if (mmss !== 16'h1234) begin failures++; $display("FAIL at_1234 got=%h exp=1234", mmss); end
    @(negedge clock_50); key_clear_n = 1'b0;
    repeat (3) @(negedge clock_50);
    tick_in = ~tick_in;
    repeat (2) @(negedge clock_50);
    checks++; if (mmss !== 16'h1234) begin failures++; $display("FAIL clear_early got=%h exp=1234", mmss); end
    @(negedge clock_50);
    checks++; if (mmss !== 16'h0000 || running !== 1'b0) begin failures++; $display("FAIL clear_tick digits=%h running=%b exp=0000 0", mmss, running); end
    key_clear_n = 1'b1;
    repeat (10) @(negedge clock_50);
    checks++; if (mmss !== 16'h0000) begin failures++; $display("FAIL clear_after got=%h exp=0000", mmss); end
  endtask

  task automatic test_reset_midcount;
    press_key(1'b0, 6);
    run_ticks(201);
    checks++; if (mmss !== 16'h0321 || running !== 1'b1) begin failures++; $display("FAIL at_0321 digits=%h running=%b exp=0321 1", mmss, running); end
    @(negedge clock_50); reset = 1'b1;
    @(negedge clock_50);
    checks++; if (mmss !== 16'h0000 || running !== 1'b0 || volta !== 1'b0) begin
      failures++; $display("FAIL midreset digits=%h running=%b volta=%b exp=0000 0 0", mmss, running, volta);
    end
    checks++; if ({hex3, hex2, hex1, hex0} !== {4{SEG_0}}) begin failures++; $display("FAIL midreset_hex got=%h exp=%h", {hex3, hex2, hex1, hex0}, {4{SEG_0}}); end
    reset = 1'b0;
    repeat (5) @(negedge clock_50);
    checks++; if (mmss !== 16'h0000 || running !== 1'b0) begin failures++; $display("FAIL post_reset digits=%h running=%b exp=0000 0", mmss, running); end
  endtask

  // Scenario sequence; each task leaves the DUT in the state the next one expects.
  initial begin
    test_reset();
    test_start_count();
    test_glitch();
    test_wrap();
    test_pause();
    test_clear_with_tick();
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
